mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 47 ++++
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 133 +++++++++++++
 tb/tb_mul_div_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared constants for the MUL AB / DIV AB execution unit.
// Provides the SFR op encodings and FSM state encodings, both as text macros
// for legacy users and as typed package items for SystemVerilog users.
// Optional feature macro (used by mul_div_unit): MULDIV_EARLY_EXIT_EN.

`ifndef MUL_DIV_UNIT_DEFINES
`define MUL_DIV_UNIT_DEFINES
`define SFR_OP_LEN      3
`define OP_NONE         3'd0
`define OP_ACC_WR_BYTE  3'd1
`define OP_B_WR_BYTE    3'd2
`define MD_IDLE         2'd0
`define MD_MUL          2'd1
`define MD_DIV          2'd2
`define MD_DONE         2'd3
`define MD_MODE_MUL     1'b0
`define MD_MODE_DIV     1'b1
`endif

package mul_div_unit_pkg;

    localparam int MD_DATA_W  = 8;
    localparam int MD_ITER    = 8;
    localparam int SFR_OP_LEN = `SFR_OP_LEN;

    typedef logic [SFR_OP_LEN-1:0] sfr_op_t;

    localparam sfr_op_t OP_NONE        = `OP_NONE;
    localparam sfr_op_t OP_ACC_WR_BYTE = `OP_ACC_WR_BYTE;
    localparam sfr_op_t OP_B_WR_BYTE   = `OP_B_WR_BYTE;

    localparam logic MODE_MUL = `MD_MODE_MUL;
    localparam logic MODE_DIV = `MD_MODE_DIV;

    typedef enum logic [1:0] {
        ST_IDLE = `MD_IDLE,
        ST_MUL  = `MD_MUL,
        ST_DIV  = `MD_DIV,
        ST_DONE = `MD_DONE
    } md_state_e;

    // A MUL result overflows the accumulator when any high-byte bit is set.
    function automatic logic mulOverflow(input logic [2*MD_DATA_W-1:0] product);
        return |product[2*MD_DATA_W-1:MD_DATA_W];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/result bundle between the core and the MUL/DIV unit.
// The core side (master) drives start/mode/operands and consumes the byte-write
// ops and PSW flags; the unit side (slave) does the reverse.

interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic                 i_start;
    logic                 i_mode;
    logic [MD_DATA_W-1:0] i_a;
    logic [MD_DATA_W-1:0] i_b;
    logic                 o_busy;
    logic                 o_done;
    logic [MD_DATA_W-1:0] o_acc_byte;
    sfr_op_t              o_acc_op;
    logic [MD_DATA_W-1:0] o_b_byte;
    sfr_op_t              o_b_op;
    logic                 o_ov;
    logic                 o_cy;

    modport master (
        output i_start, i_mode, i_a, i_b,
        input  o_busy, o_done, o_acc_byte, o_acc_op, o_b_byte, o_b_op, o_ov, o_cy
    );

    modport slave (
        input  i_start, i_mode, i_a, i_b,
        output o_busy, o_done, o_acc_byte, o_acc_op, o_b_byte, o_b_op, o_ov, o_cy
    );

endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 8-bit MUL AB / DIV AB unit feeding ACC, B and PSW.
// MUL is LSB-first shift-add into a 16-bit product; DIV is restoring division
// with a 9-bit partial remainder. Results leave as one-cycle byte-write ops.
// Optional feature macro: MULDIV_EARLY_EXIT_EN -- when defined, MUL finishes as
// soon as the remaining multiplier bits are all zero (results are unchanged).

module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int ITER   = MD_ITER
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mul_div_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    md_state_e               r_state;
    logic [DATA_W-1:0]       r_divisor;
    logic [2*DATA_W-1:0]     r_prod;
    logic [2*DATA_W-1:0]     r_mcand;
    logic [DATA_W-1:0]       r_lo;
    logic [DATA_W:0]         r_rem;
    logic [CNT_W-1:0]        r_count;

    logic [DATA_W:0]         w_shift;
    logic                    w_fits;
    logic [DATA_W:0]         w_diff;
    logic [2*DATA_W-1:0]     w_addend;
    logic                    w_iterDone;
    logic                    w_mulFinish;

    // r_lo is the multiplier during MUL and the dividend/quotient during DIV.
    assign w_shift    = {r_rem[DATA_W-1:0], r_lo[DATA_W-1]};
    assign w_fits     = (w_shift >= {1'b0, r_divisor});
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_addend   = r_lo[0] ? r_mcand : '0;
    assign w_iterDone = (r_count == CNT_W'(ITER));

`ifdef MULDIV_EARLY_EXIT_EN
    assign w_mulFinish = w_iterDone || (r_lo == '0);
`else
    assign w_mulFinish = w_iterDone;
`endif

    // Control FSM plus datapath; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_divisor      <= '0;
            r_prod         <= '0;
            r_mcand        <= '0;
            r_lo           <= '0;
            r_rem          <= '0;
            r_count        <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_acc_byte <= '0;
            bus.o_acc_op   <= OP_NONE;
            bus.o_b_byte   <= '0;
            bus.o_b_op     <= OP_NONE;
            bus.o_ov       <= 1'b0;
            bus.o_cy       <= 1'b0;
        end else begin
            bus.o_done   <= 1'b0;
            bus.o_acc_op <= OP_NONE;
            bus.o_b_op   <= OP_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_divisor  <= bus.i_b;
                        r_mcand    <= {{DATA_W{1'b0}}, bus.i_a};
                        r_lo       <= (bus.i_mode == MODE_DIV) ? bus.i_a : bus.i_b;
                        r_prod     <= '0;
                        r_rem      <= '0;
                        r_count    <= '0;
                        bus.o_busy <= 1'b1;
                        r_state    <= (bus.i_mode == MODE_DIV) ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_mulFinish) begin
                        bus.o_acc_byte <= r_prod[DATA_W-1:0];
                        bus.o_b_byte   <= r_prod[2*DATA_W-1:DATA_W];
                        bus.o_acc_op   <= OP_ACC_WR_BYTE;
                        bus.o_b_op     <= OP_B_WR_BYTE;
                        bus.o_ov       <= mulOverflow(r_prod);
                        bus.o_cy       <= 1'b0;
                        bus.o_done     <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_prod  <= r_prod + w_addend;
                        r_mcand <= r_mcand << 1;
                        r_lo    <= r_lo >> 1;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (r_divisor == '0) begin
                        bus.o_ov   <= 1'b1;
                        bus.o_cy   <= 1'b0;
                        bus.o_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (w_iterDone) begin
                        bus.o_acc_byte <= r_lo;
                        bus.o_b_byte   <= r_rem[DATA_W-1:0];
                        bus.o_acc_op   <= OP_ACC_WR_BYTE;
                        bus.o_b_op     <= OP_B_WR_BYTE;
                        bus.o_ov       <= 1'b0;
                        bus.o_cy       <= 1'b0;
                        bus.o_done     <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_rem   <= w_fits ? w_diff : w_shift;
                        r_lo    <= {r_lo[DATA_W-2:0], w_fits};
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.o_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    bus.o_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit. Expected results are
// computed with native * / % when a request is issued and compared when the
// unit pulses o_done. Latency expectations follow MULDIV_EARLY_EXIT_EN.

module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef struct {
        logic [7:0] accByte;
        logic [7:0] bByte;
        sfr_op_t    accOp;
        sfr_op_t    bOp;
        logic       ov;
        int         latency;
        int         startCycle;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst;
    expect_t sbQueue[$];
    expect_t monExp;
    expect_t lastExp;
    int      checks = 0;
    int      errors = 0;
    int      cycleCount = 0;
    int      doneCount = 0;
    int      doneBefore;
    logic [7:0] modelAcc = 8'h00;
    logic [7:0] modelB = 8'h00;
    logic    expectIdleNext = 1'b0;

    mul_div_unit_if bus();

    mul_div_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure start-to-done latency.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int mulLatency(input logic [7:0] b);
        int n;
        n = 0;
`ifdef MULDIV_EARLY_EXIT_EN
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`else
        n = 8;
`endif
        return n + 1;
    endfunction

    // Monitor: pop the scoreboard on every done pulse, then confirm the unit idles next cycle.
    always @(negedge clk) begin
        if (expectIdleNext) begin
            expectIdleNext = 1'b0;
            checkOutput("idle_busy", bus.o_busy, 1'b0);
            checkOutput("idle_done", bus.o_done, 1'b0);
            checkOutput("idle_acc_op", bus.o_acc_op, OP_NONE);
            checkOutput("idle_b_op", bus.o_b_op, OP_NONE);
            checkOutput("hold_acc_byte", bus.o_acc_byte, lastExp.accByte);
            checkOutput("hold_b_byte", bus.o_b_byte, lastExp.bByte);
        end
        if (rst === 1'b0 && bus.o_done === 1'b1) begin
            doneCount++;
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_done", 1'b1, 1'b0);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("acc_byte", bus.o_acc_byte, monExp.accByte);
                checkOutput("b_byte", bus.o_b_byte, monExp.bByte);
                checkOutput("acc_op", bus.o_acc_op, monExp.accOp);
                checkOutput("b_op", bus.o_b_op, monExp.bOp);
                checkOutput("ov", bus.o_ov, monExp.ov);
                checkOutput("cy", bus.o_cy, 1'b0);
                checkOutput("busy_in_done", bus.o_busy, 1'b1);
                checkOutput("latency", cycleCount - monExp.startCycle, monExp.latency);
                lastExp = monExp;
                expectIdleNext = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic mode, input logic [7:0] a, input logic [7:0] b);
        expect_t    e;
        logic [15:0] p;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_mode  = mode;
        bus.i_a     = a;
        bus.i_b     = b;
        if (mode == MODE_MUL) begin
            p = 16'(a) * 16'(b);
            e.accByte = p[7:0];
            e.bByte   = p[15:8];
            e.accOp   = OP_ACC_WR_BYTE;
            e.bOp     = OP_B_WR_BYTE;
            e.ov      = (p[15:8] != 8'h00);
            e.latency = mulLatency(b);
        end else if (b == 8'h00) begin
            e.accByte = modelAcc;
            e.bByte   = modelB;
            e.accOp   = OP_NONE;
            e.bOp     = OP_NONE;
            e.ov      = 1'b1;
            e.latency = 1;
        end else begin
            e.accByte = a / b;
            e.bByte   = a % b;
            e.accOp   = OP_ACC_WR_BYTE;
            e.bOp     = OP_B_WR_BYTE;
            e.ov      = 1'b0;
            e.latency = 9;
        end
        modelAcc = e.accByte;
        modelB   = e.bByte;
        @(posedge clk);
        #1;
        e.startCycle = cycleCount;
        sbQueue.push_back(e);
        bus.i_start = 1'b0;
        checkOutput("busy_after_start", bus.o_busy, 1'b1);
    endtask

    task automatic waitDrain(input string tag);
        int budget;
        budget = 0;
        while ((sbQueue.size() != 0 || bus.o_busy !== 1'b0) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, "_drained"}, (sbQueue.size() == 0 && bus.o_busy === 1'b0), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_a     = 8'h00;
        bus.i_b     = 8'h00;
        lastExp     = '{8'h00, 8'h00, OP_NONE, OP_NONE, 1'b0, 0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", bus.o_busy, 1'b0);
        checkOutput("rst_done", bus.o_done, 1'b0);
        checkOutput("rst_acc_byte", bus.o_acc_byte, 8'h00);
        checkOutput("rst_b_byte", bus.o_b_byte, 8'h00);
        checkOutput("rst_acc_op", bus.o_acc_op, OP_NONE);
        checkOutput("rst_b_op", bus.o_b_op, OP_NONE);
        checkOutput("rst_ov", bus.o_ov, 1'b0);
        checkOutput("rst_cy", bus.o_cy, 1'b0);
        rst = 1'b0;

        $display("[TB] directed MUL/DIV cases");
        applyStimulus(MODE_MUL, 8'h50, 8'hA0); waitDrain("mul_50_a0");
        applyStimulus(MODE_MUL, 8'h07, 8'h06); waitDrain("mul_07_06");
        applyStimulus(MODE_DIV, 8'hFB, 8'h12); waitDrain("div_fb_12");
        applyStimulus(MODE_DIV, 8'h55, 8'h00); waitDrain("div_by_zero");
        applyStimulus(MODE_MUL, 8'h9C, 8'h00); waitDrain("mul_by_zero");

        $display("[TB] reset during MUL");
        applyStimulus(MODE_MUL, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sbQueue.delete();
        modelAcc = 8'h00;
        modelB   = 8'h00;
        lastExp  = '{8'h00, 8'h00, OP_NONE, OP_NONE, 1'b0, 0, 0};
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", bus.o_busy, 1'b0);
        checkOutput("abort_done", bus.o_done, 1'b0);
        checkOutput("abort_acc_byte", bus.o_acc_byte, 8'h00);
        checkOutput("abort_b_byte", bus.o_b_byte, 8'h00);
        checkOutput("abort_ov", bus.o_ov, 1'b0);
        doneBefore = doneCount;
        repeat (12) @(negedge clk);
        checkOutput("abort_no_done", doneCount - doneBefore, 0);
        applyStimulus(MODE_MUL, 8'hFF, 8'hFF); waitDrain("mul_ff_ff");

        $display("[TB] start pulses while busy");
        doneBefore = doneCount;
        applyStimulus(MODE_DIV, 8'h64, 8'h07);
        repeat (3) @(negedge clk);
        bus.i_start = 1'b1; bus.i_mode = MODE_MUL; bus.i_a = 8'hFF; bus.i_b = 8'hFF;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        checkOutput("busy_low_c10", bus.o_busy, 1'b0);
        repeat (12) @(negedge clk);
        checkOutput("single_done", doneCount - doneBefore, 1);
        checkOutput("ignored_start_queue", sbQueue.size(), 0);

        $display("[TB] random operands");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          (n == 3) ? 8'h00 : 8'($urandom_range(0, 255)));
            waitDrain("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
